markov_lane_sched: RTL and testbench
====================================

MARKOV_LANE_SCHED -- requirements
Module: markov_lane_sched

Interface
REQ-001 Parameter N_LANES, default 16: number of Markov lanes; in_lane width is log2(N_LANES) = 4.
REQ-002 Parameter DEPTH, default 6: per-lane buffer depth; equals the write-port width of the downstream 16-bit FIFO.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  a classified bit is present this cycle.
REQ-006 in_lane  input  4  Markov lane (previous 4-bit history) of the incoming bit.
REQ-007 in_bit  input  1  the incoming bit.
REQ-008 flush  input  1  single-cycle pulse requesting drain of all partially filled lanes.
REQ-009 out_valid  output  6  per-bit valid mask toward the FIFO write port.
REQ-010 out_bits  output  6  packed lane bits toward the FIFO; bit k pairs with out_valid[k].
REQ-011 out_lane  output  4  lane whose bits are on out_bits; 0 when out_valid is 0.
REQ-012 flush_done  output  1  one-cycle pulse when a flush completes.
REQ-013 drop_cnt  output  16  saturating count of discarded input bits.

Function
REQ-014 Each lane SHALL hold a DEPTH-bit buffer and a 3-bit fill count; an accepted bit is written at index count (oldest bit at index 0), then count increments.
REQ-015 State machine SHALL have two states: RUN and FLUSH; RUN -> FLUSH on flush=1; FLUSH -> RUN once no lane has count>0, with flush_done=1 for exactly that transition cycle.
REQ-016 In RUN, a lane SHALL be eligible when count==DEPTH; in FLUSH, when count>0.
REQ-017 A round-robin arbiter SHALL grant at most one eligible lane per cycle, searching upward from (last granted lane + 1) mod N_LANES; the pointer resets to lane 0.
REQ-018 The grant SHALL be registered: one cycle after the grant decision, out_bits = granted buffer, out_valid = (1<<count)-1 (6'b111111 when full), out_lane = lane; outputs otherwise 0.
REQ-019 A granted lane SHALL be cleared in the grant cycle; if an in_valid bit for the same lane arrives in that cycle, it SHALL become index 0 with count=1.
REQ-020 An in_valid bit for a lane at count==DEPTH and not granted that cycle SHALL be discarded and drop_cnt incremented.
REQ-021 In FLUSH, all in_valid bits SHALL be discarded and counted in drop_cnt.
REQ-022 drop_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-023 flush while already in FLUSH SHALL be ignored; flush with all lanes empty SHALL give RUN -> FLUSH -> RUN with flush_done one cycle after the flush cycle.
REQ-024 There SHALL be no backpressure; the downstream FIFO accepts every out_valid pattern.

Reset
REQ-025 reset SHALL clear all buffers, counts, drop_cnt and the arbiter pointer, enter RUN, and drive out_valid, out_bits, out_lane and flush_done to 0 on the next edge.
REQ-026 reset SHALL take priority over flush and in_valid in the same cycle; reset mid-FLUSH SHALL abort without a flush_done pulse.

Structure
REQ-027 N_LANES, DEPTH, lane-index width, count width and the RUN/FLUSH state encoding SHALL live in a shared package markov_pkg.
REQ-028 Round-robin selection SHALL be a separate sub-module rr_arbiter16 (16-bit request vector, 4-bit pointer in, one-hot grant plus 4-bit index out, grant-valid flag).

Verification
REQ-029 Six bits 1,0,1,1,0,0 on lane 3 -> one cycle after the 6th bit: out_valid=6'b111111, out_bits=6'b001101, out_lane=3.
REQ-030 Lanes 2 and 9 full in the same cycle, pointer 0 -> lane 2 output first, lane 9 on the next cycle.
REQ-031 Lane 5 full and not granted (lane 4 wins), 7th bit for lane 5 -> drop_cnt 0->1; lane 5 output is the original 6 bits.
REQ-032 Lane 1 holds 3 bits (1,1,0) and lane 7 holds 1 bit (1), then flush -> out_valid=6'b000111 with out_bits=6'b000011 for lane 1, then 6'b000001 with out_bits=6'b000001 for lane 7, flush_done one cycle after lane 7 is granted.
REQ-033 Lane 0 being granted while a new bit 1 arrives for lane 0 -> full word output; lane 0 count=1 with buffer index 0 = 1.
REQ-034 reset asserted mid-FLUSH with three lanes pending -> next cycle all outputs 0, no flush_done, drop_cnt 0; normal packing resumes.

Source files
------------

// File: rtl/markov_pkg.sv
// Shared constants and state encoding for the Markov lane scheduler.
package markov_pkg;
  localparam int N_LANES = 16;
  localparam int DEPTH   = 6;
  localparam int LANE_W  = 4;
  localparam int CNT_W   = 3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sched_state_t;
endpackage

// File: rtl/rr_arbiter16.sv
// Sixteen-way round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter16 (
  input  logic [15:0] req,
  input  logic [3:0]  ptr,
  output logic [15:0] gnt,
  output logic [3:0]  idx,
  output logic        gnt_valid
);
  always_comb begin
    gnt       = '0;
    idx       = '0;
    gnt_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!gnt_valid && req[ptr + 4'(i)]) begin
        gnt_valid = 1'b1;
        idx       = ptr + 4'(i);
      end
    end
    gnt[idx] = gnt_valid;
  end
endmodule

// File: rtl/markov_lane_sched.sv
// Packs classified bits into per-lane buffers and drains full (or, on flush, partial) lanes.
module markov_lane_sched #(
  parameter int N_LANES = markov_pkg::N_LANES,
  parameter int DEPTH   = markov_pkg::DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [markov_pkg::LANE_W-1:0] in_lane,
  input  logic                          in_bit,
  input  logic                          flush,
  output logic [DEPTH-1:0]              out_valid,
  output logic [DEPTH-1:0]              out_bits,
  output logic [markov_pkg::LANE_W-1:0] out_lane,
  output logic                          flush_done,
  output logic [15:0]                   drop_cnt
);
  import markov_pkg::*;

  function automatic logic [DEPTH-1:0] fill_mask(input logic [CNT_W-1:0] cnt);
    logic [DEPTH-1:0] m;
    for (int i = 0; i < DEPTH; i++) m[i] = (i < int'(cnt));
    return m;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DEPTH-1:0]  buf_q [N_LANES];
  logic [CNT_W-1:0]  cnt_q [N_LANES];
  sched_state_t      state_q, state_n;
  logic [LANE_W-1:0] ptr_q;
  logic [15:0]       req;
  logic [15:0]       gnt;
  logic [LANE_W-1:0] gnt_idx;
  logic              gnt_valid;
  logic              any_pending;
  logic              hit, in_full, accept, drop;

  always_comb begin
    req         = '0;
    any_pending = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (cnt_q[i] != '0) any_pending = 1'b1;
      req[i] = (state_q == FLUSH) ? (cnt_q[i] != '0) : (cnt_q[i] == CNT_W'(DEPTH));
    end
  end

  rr_arbiter16 u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .idx       (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_n    = state_q;
    flush_done = 1'b0;
    case (state_q)
      RUN:   if (flush) state_n = FLUSH;
      FLUSH: if (!any_pending) begin
        state_n    = RUN;
        flush_done = 1'b1;
      end
    endcase
  end

  // A lane being drained this cycle has room again, so its new bit lands at index 0.
  always_comb begin
    hit     = gnt[in_lane];
    in_full = (cnt_q[in_lane] == CNT_W'(DEPTH));
    accept  = in_valid && (state_q == RUN) && (!in_full || hit);
    drop    = in_valid && !accept;
  end

  // Stage boundary: grant decision -> registered FIFO write word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      ptr_q     <= '0;
      drop_cnt  <= '0;
      out_valid <= '0;
      out_bits  <= '0;
      out_lane  <= '0;
      for (int i = 0; i < N_LANES; i++) begin
        buf_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_n;
      if (gnt_valid) begin
        ptr_q     <= gnt_idx + LANE_W'(1);
        out_valid <= fill_mask(cnt_q[gnt_idx]);
        out_bits  <= buf_q[gnt_idx];
        out_lane  <= gnt_idx;
      end else begin
        out_valid <= '0;
        out_bits  <= '0;
        out_lane  <= '0;
      end
      for (int i = 0; i < N_LANES; i++) begin
        if (gnt[i]) begin
          buf_q[i] <= '0;
          cnt_q[i] <= '0;
        end
      end
      if (accept) begin
        if (hit) begin
          buf_q[in_lane] <= {{(DEPTH-1){1'b0}}, in_bit};
          cnt_q[in_lane] <= CNT_W'(1);
        end else begin
          buf_q[in_lane][cnt_q[in_lane]] <= in_bit;
          cnt_q[in_lane] <= cnt_q[in_lane] + CNT_W'(1);
        end
      end
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end
endmodule

// File: tb/tb_markov_lane_sched.sv
// Scoreboard bench for markov_lane_sched with a queue-based lane model.
module tb_markov_lane_sched;
  logic       clk = 1'b0;
  logic       reset, in_valid, in_bit, flush;
  logic [3:0] in_lane;
  logic [5:0] out_valid, out_bits;
  logic [3:0] out_lane;
  logic       flush_done;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int       due;
    logic [5:0] v;
    logic [5:0] b;
    logic [3:0] l;
  } exp_t;

  exp_t sb[$];
  bit   lanes[16][$];
  int   m_ptr = 0;
  bit   m_flush = 1'b0;
  int   m_drop = 0;

  markov_lane_sched dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_lane    (in_lane),
    .in_bit     (in_bit),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_bits   (out_bits),
    .out_lane   (out_lane),
    .flush_done (flush_done),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 16; i++) if (lanes[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: one call per clock cycle, with the inputs applied that cycle.
  task automatic drive(input bit v, input int lane, input bit b, input bit f, input bit r);
    int  g;
    int  ln;
    bit  empty_now;
    exp_t e;
    in_valid = v; in_lane = 4'(lane); in_bit = b; flush = f; reset = r;
    if (r) begin
      for (int i = 0; i < 16; i++) lanes[i].delete();
      m_ptr = 0; m_flush = 1'b0; m_drop = 0;
      return;
    end
    empty_now = all_empty();
    g = -1;
    for (int k = 0; k < 16; k++) begin
      ln = (m_ptr + k) % 16;
      if (g < 0 && (m_flush ? lanes[ln].size() > 0 : lanes[ln].size() == 6)) g = ln;
    end
    if (g >= 0) begin
      e.due = cyc + 1;
      e.l   = 4'(g);
      e.v   = 6'((1 << lanes[g].size()) - 1);
      e.b   = '0;
      for (int k = 0; k < lanes[g].size(); k++) e.b[k] = lanes[g][k];
      sb.push_back(e);
      lanes[g].delete();
      m_ptr = (g + 1) % 16;
    end
    if (v) begin
      if (m_flush || lanes[lane].size() == 6) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        lanes[lane].push_back(b);
      end
    end
    if (m_flush) begin
      if (empty_now) m_flush = 1'b0;
    end else if (f) begin
      m_flush = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("flush_done", 32'(flush_done), 32'(m_flush && all_empty()));
  endtask

  task automatic step(input bit v, input int lane, input bit b, input bit f, input bit r);
    tick();
    drive(v, lane, b, f, r);
  endtask

  task automatic chk_out(input string name, input logic [5:0] v, input logic [5:0] b, input logic [3:0] l);
    chk({name, "_valid"}, 32'(out_valid), 32'(v));
    chk({name, "_bits"}, 32'(out_bits), 32'(b));
    chk({name, "_lane"}, 32'(out_lane), 32'(l));
  endtask

  task automatic fill(input int lane, input logic [5:0] pat, input int n);
    logic [5:0] p;
    p = pat;
    for (int k = 0; k < n; k++) step(1'b1, lane, p[k], 1'b0, 1'b0);
  endtask

  // Monitor: compares every FIFO write word against the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          checks++; errors++;
          $display("FAIL missing_word: lane %0d due cycle %0d not seen", e.l, e.due);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          chk("word_valid", 32'(out_valid), 32'(e.v));
          chk("word_bits", 32'(out_bits), 32'(e.b));
          chk("word_lane", 32'(out_lane), 32'(e.l));
        end else begin
          chk("idle_valid", 32'(out_valid), 32'd0);
          chk("idle_bits", 32'(out_bits), 32'd0);
          chk("idle_lane", 32'(out_lane), 32'd0);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_lane = '0; in_bit = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    step(0, 0, 0, 0, 1);
    tick(); chk_out("reset", 6'd0, 6'd0, 4'd0); drive(0, 0, 0, 0, 0);

    // Lane 3 packs 1,0,1,1,0,0
    fill(3, 6'b001101, 6);
    step(0, 0, 0, 0, 0);
    tick(); chk_out("lane3_full", 6'b111111, 6'b001101, 4'd3); drive(0, 0, 0, 0, 0);

    // Partial lanes 1 and 7 drained by flush
    step(0, 0, 0, 0, 1);
    fill(1, 6'b000011, 3);
    fill(7, 6'b000001, 1);
    step(0, 0, 0, 1, 0);
    tick(); chk_out("flush_wait", 6'd0, 6'd0, 4'd0); drive(0, 0, 0, 0, 0);
    tick(); chk_out("flush_lane1", 6'b000111, 6'b000011, 4'd1); drive(0, 0, 0, 0, 0);
    tick(); chk_out("flush_lane7", 6'b000001, 6'b000001, 4'd7);
    chk("flush_done_pulse", 32'(flush_done), 32'd1); drive(0, 0, 0, 0, 0);
    tick(); chk("flush_done_end", 32'(flush_done), 32'd0); drive(0, 0, 0, 0, 0);

    // Lanes 2 and 9 pending together from pointer 0, with a drop during FLUSH
    step(0, 0, 0, 0, 1);
    fill(9, 6'b000001, 2);
    fill(2, 6'b000110, 3);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    tick(); chk_out("order_lane2", 6'b000111, 6'b000110, 4'd2); drive(1, 5, 1, 0, 0);
    tick(); chk_out("order_lane9", 6'b000011, 6'b000001, 4'd9); drive(0, 0, 0, 0, 0);
    tick(); chk("drop_in_flush", 32'(drop_cnt), 32'd1); drive(0, 0, 0, 0, 0);

    // Lane 0 refilled in its own grant cycle
    step(0, 0, 0, 0, 1);
    fill(0, 6'b110010, 6);
    step(1, 0, 1, 0, 0);
    tick(); chk_out("lane0_first", 6'b111111, 6'b110010, 4'd0); drive(1, 0, 0, 0, 0);
    fill(0, 6'b000000, 4);
    step(0, 0, 0, 0, 0);
    tick(); chk_out("lane0_second", 6'b111111, 6'b000001, 4'd0); drive(0, 0, 0, 0, 0);

    // Reset in the middle of a flush
    fill(4, 6'b000010, 2);
    fill(5, 6'b000001, 1);
    fill(6, 6'b000101, 3);
    step(0, 0, 0, 1, 0);
    step(1, 8, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    tick(); chk_out("abort", 6'd0, 6'd0, 4'd0);
    chk("abort_done", 32'(flush_done), 32'd0);
    chk("abort_drop", 32'(drop_cnt), 32'd0); drive(0, 0, 0, 0, 0);
    fill(3, 6'b101011, 6);
    step(0, 0, 0, 0, 0);
    tick(); chk_out("resume", 6'b111111, 6'b101011, 4'd3); drive(0, 0, 0, 0, 0);

    // Randomised traffic with occasional flush and reset
    for (int n = 0; n < 4000; n++) begin
      bit v, f, r;
      int lane;
      v = ($urandom_range(0, 9) < 7);
      lane = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      f = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 799) == 0);
      step(v, lane, 1'($urandom_range(0, 1)), f, r);
    end

    repeat (20) step(0, 0, 0, 0, 0);
    tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
